// File: rtl/regfile_port_arbiter.sv
// Register-file port arbiter: shares the single write port and read port 1
// between the core writeback path and a debug access channel. The core has
// priority; debug writes use idle writeback slots, and debug reads (or writes
// that have waited MAX_WAIT cycles) steal one stalled core cycle. x0 is never
// written by either requester.
module regfile_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_we,
  input  logic [4:0]  core_a3,
  input  logic [31:0] core_wd,
  input  logic [4:0]  core_a1,
  output logic        core_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd,
  output logic [4:0]  rf_a1,
  input  logic [31:0] rf_rd1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    STALL = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       dbg_rdata_q, dbg_rdata_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;

  // A core cycle that does not need the write port (x0 writes are dropped anyway)
  logic core_free;
  assign core_free = ~core_we | (core_a3 == 5'd0);

  // State, wait counter and registered read response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dbg_rdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  // Next-state logic and port steering; core pass-through unless debug owns the ports
  always_comb begin
    logic dbg_wr_commit;
    state_d       = state_q;
    cnt_d         = cnt_q;
    dbg_rdata_d   = dbg_rdata_q;
    dbg_rvalid_d  = 1'b0;
    dbg_wr_commit = 1'b0;
    rf_we         = core_we & (core_a3 != 5'd0);
    rf_a3         = core_a3;
    rf_wd         = core_wd;
    rf_a1         = core_a1;
    core_stall    = 1'b0;
    dbg_gnt       = 1'b0;

    case (state_q)
      IDLE: begin
        if (dbg_req) begin
          if (dbg_we) begin
            if (core_free) begin
              dbg_wr_commit = 1'b1;
            end else if (MAX_WAIT == 0) begin
              state_d = STALL;
            end else begin
              state_d = PEND;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            state_d = STALL;
          end
        end
      end

      PEND: begin
        if (core_free) begin
          dbg_wr_commit = 1'b1;
          state_d       = IDLE;
          cnt_d         = '0;
        end else if (cnt_q == MAX_CNT) begin
          state_d = STALL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STALL: begin
        // Core is held this cycle, so its writeback is dropped and debug owns both ports
        core_stall = 1'b1;
        dbg_gnt    = 1'b1;
        rf_a1      = dbg_addr;
        rf_a3      = dbg_addr;
        rf_wd      = dbg_wdata;
        if (dbg_we) begin
          rf_we   = (dbg_addr != 5'd0);
          state_d = IDLE;
        end else begin
          rf_we        = 1'b0;
          dbg_rdata_d  = (dbg_addr == 5'd0) ? 32'd0 : rf_rd1;
          dbg_rvalid_d = 1'b1;
          state_d      = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (dbg_wr_commit) begin
      dbg_gnt = 1'b1;
      rf_we   = (dbg_addr != 5'd0);
      rf_a3   = dbg_addr;
      rf_wd   = dbg_wdata;
    end
  end

  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;

endmodule
